// File: rtl/calc1_reference_if.sv
// Request/response bundle shared by the four calculator ports.
// All vectors are MSB-first: bit 0 is the most significant bit.
interface calc1_reference_if;
  logic [0:3]  req1_cmd_in;
  logic [0:3]  req2_cmd_in;
  logic [0:3]  req3_cmd_in;
  logic [0:3]  req4_cmd_in;
  logic [0:31] req1_data_in;
  logic [0:31] req2_data_in;
  logic [0:31] req3_data_in;
  logic [0:31] req4_data_in;
  logic [0:31] out_data1;
  logic [0:31] out_data2;
  logic [0:31] out_data3;
  logic [0:31] out_data4;
  logic [0:1]  out_resp1;
  logic [0:1]  out_resp2;
  logic [0:1]  out_resp3;
  logic [0:1]  out_resp4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_resp1, out_resp2, out_resp3, out_resp4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_data1, out_data2, out_data3, out_data4,
    output out_resp1, out_resp2, out_resp3, out_resp4
  );
endinterface

// File: rtl/calc1_reference.sv
// Four independent 32-bit calculator ports (add/sub/shl/shr).
// Each port takes a command, then a second operand, then presents its result for one cycle.
module calc1_reference (
  input  logic               c_clk,
  input  logic [1:7]         reset,
  calc1_reference_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  logic        w_rst;
  logic [0:3]  w_cmd [4];
  logic [0:31] w_din [4];

  // Any single reset bit holds the whole block in reset.
  assign w_rst = |reset;

  assign w_cmd[0] = bus.req1_cmd_in;
  assign w_cmd[1] = bus.req2_cmd_in;
  assign w_cmd[2] = bus.req3_cmd_in;
  assign w_cmd[3] = bus.req4_cmd_in;
  assign w_din[0] = bus.req1_data_in;
  assign w_din[1] = bus.req2_data_in;
  assign w_din[2] = bus.req3_data_in;
  assign w_din[3] = bus.req4_data_in;

  // Returns {resp[0:1], data[0:31]}; errors always carry zero data.
  function automatic logic [0:33] calc(input logic [0:3] cmd,
                                       input logic [0:31] op1,
                                       input logic [0:31] op2);
    logic [0:32] sum;
    logic [0:33] res;
    sum = 33'd0;
    res = {2'd2, 32'd0};
    case (cmd)
      4'd1: begin
        sum = {1'b0, op1} + {1'b0, op2};
        if (sum[0]) res = {2'd2, 32'd0};
        else        res = {2'd1, sum[1:32]};
      end
      4'd2: begin
        if (op2 > op1) res = {2'd2, 32'd0};
        else           res = {2'd1, op1 - op2};
      end
      4'd5:    res = {2'd1, op1 << op2[27:31]};
      4'd6:    res = {2'd1, op1 >> op2[27:31]};
      default: res = {2'd2, 32'd0};
    endcase
    return res;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_port
    state_t      r_state;
    state_t      w_state_nxt;
    logic [0:3]  r_cmd;
    logic [0:31] r_op1;
    logic [0:31] r_op2;
    logic [0:31] r_data;
    logic [0:1]  r_resp;
    logic [0:33] w_res;

    assign w_res = calc(r_cmd, r_op1, r_op2);

    // State register.
    always_ff @(posedge c_clk or posedge w_rst) begin
      if (w_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
    end

    // Next-state: the command edge leaves IDLE, then two fixed steps back to IDLE.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd[g] != 4'd0) w_state_nxt = ST_OP2;
          else                  w_state_nxt = ST_IDLE;
        end
        ST_OP2:  w_state_nxt = ST_EXEC;
        ST_EXEC: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Operand capture; in-flight operands are dropped on reset.
    always_ff @(posedge c_clk or posedge w_rst) begin
      if (w_rst) begin
        r_cmd <= 4'd0;
        r_op1 <= 32'd0;
        r_op2 <= 32'd0;
      end else begin
        if (r_state == ST_IDLE && w_cmd[g] != 4'd0) begin
          r_cmd <= w_cmd[g];
          r_op1 <= w_din[g];
        end
        if (r_state == ST_OP2) r_op2 <= w_din[g];
      end
    end

    // Result registers: loaded from EXEC, otherwise cleared so idle outputs read zero.
    always_ff @(posedge c_clk or posedge w_rst) begin
      if (w_rst) begin
        r_resp <= 2'd0;
        r_data <= 32'd0;
      end else if (r_state == ST_EXEC) begin
        r_resp <= w_res[0:1];
        r_data <= w_res[2:33];
      end else begin
        r_resp <= 2'd0;
        r_data <= 32'd0;
      end
    end
  end

  assign bus.out_data1 = g_port[0].r_data;
  assign bus.out_data2 = g_port[1].r_data;
  assign bus.out_data3 = g_port[2].r_data;
  assign bus.out_data4 = g_port[3].r_data;
  assign bus.out_resp1 = g_port[0].r_resp;
  assign bus.out_resp2 = g_port[1].r_resp;
  assign bus.out_resp3 = g_port[2].r_resp;
  assign bus.out_resp4 = g_port[3].r_resp;

endmodule

// File: tb/tb_calc1_reference.sv
// Directed bench for calc1_reference: a scoreboard of expected responses keyed by cycle,
// checked on every falling edge, plus literal checks at the interesting moments.
module tb_calc1_reference;

  logic       c_clk = 1'b0;
  logic [1:7] reset;

  calc1_reference_if bus();

  calc1_reference dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    int          due;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic [3:0]  tb_cmd  [4];
  logic [31:0] tb_data [4];
  logic [31:0] tb_op2  [4];
  int          ph      [4];
  logic [31:0] obs_data [4];
  logic [1:0]  obs_resp [4];
  exp_t        q [4][$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  assign bus.req1_cmd_in  = tb_cmd[0];
  assign bus.req2_cmd_in  = tb_cmd[1];
  assign bus.req3_cmd_in  = tb_cmd[2];
  assign bus.req4_cmd_in  = tb_cmd[3];
  assign bus.req1_data_in = tb_data[0];
  assign bus.req2_data_in = tb_data[1];
  assign bus.req3_data_in = tb_data[2];
  assign bus.req4_data_in = tb_data[3];
  assign obs_data[0] = bus.out_data1;
  assign obs_data[1] = bus.out_data2;
  assign obs_data[2] = bus.out_data3;
  assign obs_data[3] = bus.out_data4;
  assign obs_resp[0] = bus.out_resp1;
  assign obs_resp[1] = bus.out_resp2;
  assign obs_resp[2] = bus.out_resp3;
  assign obs_resp[3] = bus.out_resp4;

  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Plain unsigned arithmetic from the command definitions.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    longint unsigned s;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(s); end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
      default: begin r = 2'd2; d = 32'd0; end
    endcase
  endfunction

  // Every falling edge: each port shows its due result or zero.
  always @(negedge c_clk) begin : cmp
    logic [1:0]  er;
    logic [31:0] ed;
    for (int p = 0; p < 4; p++) begin
      er = 2'd0;
      ed = 32'd0;
      while (q[p].size() > 0 && q[p][0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_resp port%0d: due cycle %0d not seen", p + 1, q[p][0].due);
        void'(q[p].pop_front());
      end
      if (q[p].size() > 0 && q[p][0].due == cyc) begin
        er = q[p][0].resp;
        ed = q[p][0].data;
        void'(q[p].pop_front());
      end
      chk($sformatf("resp%0d", p + 1), 32'(obs_resp[p]), 32'(er));
      chk($sformatf("data%0d", p + 1), obs_data[p], ed);
    end
  end

  // Call right after a falling edge; the result is due three rising edges later.
  task automatic start(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    tb_cmd[p]  = c;
    tb_data[p] = a;
    tb_op2[p]  = b;
    ph[p]      = 1;
    e.due = cyc + 3;
    model(c, a, b, e.resp, e.data);
    q[p].push_back(e);
  endtask

  // One cycle of stimulus; cmd is garbage while the port waits for op2 and data is garbage during EXEC.
  task automatic step();
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      if (ph[p] == 1) begin
        tb_cmd[p] = 4'h7; tb_data[p] = tb_op2[p]; ph[p] = 2;
      end else if (ph[p] == 2) begin
        tb_cmd[p] = 4'h0; tb_data[p] = $urandom; ph[p] = 3;
      end else if (ph[p] == 3) begin
        tb_data[p] = 32'h0; ph[p] = 0;
      end
    end
  endtask

  task automatic advance();
    repeat (3) step();
  endtask

  task automatic clear_stim();
    for (int p = 0; p < 4; p++) begin
      tb_cmd[p] = 4'h0; tb_data[p] = 32'h0; tb_op2[p] = 32'h0; ph[p] = 0;
      q[p].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 7'h7F;
    clear_stim();
    repeat (3) @(negedge c_clk);
    chk("rst_resp1", 32'(bus.out_resp1), 32'd0);
    chk("rst_data4", bus.out_data4, 32'd0);
    reset = 7'h00;

    // Idle: data toggling with cmd 0 never produces output.
    repeat (4) step();
    tb_data[0] = 32'd255;
    repeat (6) step();
    tb_data[0] = 32'd0;
    step();

    // Port1 add, then a back-to-back overflowing add.
    start(0, 4'd1, 32'h0000_0005, 32'h0000_0007);
    advance();
    chk("add_resp", 32'(bus.out_resp1), 32'd1);
    chk("add_data", bus.out_data1, 32'h0000_000C);
    start(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    advance();
    chk("add_ovf_resp", 32'(bus.out_resp1), 32'd2);
    chk("add_ovf_data", bus.out_data1, 32'h0);
    step();
    chk("add_cleared", 32'(bus.out_resp1), 32'd0);

    // Port2 subtracts.
    start(1, 4'd2, 32'd10, 32'd3);
    advance();
    chk("sub_data", bus.out_data2, 32'd7);
    start(1, 4'd2, 32'd3, 32'd10);
    advance();
    chk("sub_unf_resp", 32'(bus.out_resp2), 32'd2);
    start(1, 4'd2, 32'h8000_0000, 32'h8000_0000);
    advance();
    chk("sub_eq_resp", 32'(bus.out_resp2), 32'd1);
    chk("sub_eq_data", bus.out_data2, 32'h0);

    // Shifts on ports 3 and 4 together.
    start(2, 4'd5, 32'h0000_0001, 32'hFFFF_FFE4);
    start(3, 4'd6, 32'h8000_0000, 32'd31);
    advance();
    chk("shl_data", bus.out_data3, 32'h0000_0010);
    chk("shr_data", bus.out_data4, 32'h0000_0001);
    chk("shr_resp", 32'(bus.out_resp4), 32'd1);

    // Invalid on port1 while ports 2-4 add in the same cycle.
    start(0, 4'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    start(1, 4'd1, 32'd1, 32'd2);
    start(2, 4'd1, 32'h0000_0100, 32'h0000_0200);
    start(3, 4'd1, 32'h7FFF_FFFF, 32'h0000_0001);
    advance();
    chk("inv_resp1", 32'(bus.out_resp1), 32'd2);
    chk("inv_data1", bus.out_data1, 32'h0);
    chk("conc_data2", bus.out_data2, 32'd3);
    chk("conc_data3", bus.out_data3, 32'h0000_0300);
    chk("conc_data4", bus.out_data4, 32'h8000_0000);

    // More corners handled by the scoreboard alone.
    start(0, 4'd4, 32'd1, 32'd1);
    start(1, 4'd1, 32'hFFFF_FFFE, 32'd1);
    start(2, 4'd5, 32'hF000_000F, 32'h0000_0020);
    start(3, 4'd15, 32'd0, 32'd0);
    advance();
    start(0, 4'd6, 32'hDEAD_BEEF, 32'd4);
    start(2, 4'd5, 32'hDEAD_BEEF, 32'd31);
    advance();
    step();

    // Reset on port1 during OP2 while port2 is presenting a result.
    start(1, 4'd2, 32'd9, 32'd4);
    step();
    step();
    start(0, 4'd1, 32'h11, 32'h22);
    step();
    #2;
    reset = 7'b0001000;
    clear_stim();
    #1;
    chk("async_rst_data2", bus.out_data2, 32'h0);
    chk("async_rst_resp2", 32'(bus.out_resp2), 32'd0);
    repeat (3) @(negedge c_clk);
    reset = 7'h00;
    repeat (5) step();
    start(0, 4'd1, 32'd2, 32'd2);
    advance();
    chk("post_rst_resp", 32'(bus.out_resp1), 32'd1);
    chk("post_rst_data", bus.out_data1, 32'd4);

    repeat (4) step();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (q[p].size() != 0) begin
        failures++;
        $display("FAIL drain port%0d: %0d responses outstanding, expected 0", p + 1, q[p].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
